// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: iterative CORDIC, one micro-rotation per clock, rotation and vectoring modes
module cordic_iter_engine #(
  parameter int WIDTH    = 17,
  parameter int ANG_FRAC = 8,
  parameter int ITER     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] theta_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] theta_o,
  output logic                    busy
);
  localparam int IW = WIDTH + 2;
  localparam int CW = 5;
  localparam int SH = 16 - ANG_FRAC;
  localparam int RND = (1 << SH) >> 1;
  localparam logic signed [IW-1:0] DEG90 = IW'(90 << ANG_FRAC);
  localparam logic signed [IW-1:0] DEG180 = IW'(180 << ANG_FRAC);
  localparam logic signed [IW-1:0] SMAX = IW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] SMIN = ~SMAX;
  localparam int ATAN [16] = '{2949120, 1740967, 919879, 466945, 234379, 117304, 58666, 29335,
                               14668, 7334, 3667, 1833, 917, 458, 229, 115};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic md, flip, hi, lo, pos;
  logic [CW-1:0] cnt;
  logic signed [IW-1:0] x, y, z, xe, ye, te, z0, xsh, ysh, at, x_nx, y_nx, z_nx;
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    return v > SMAX ? WIDTH'(SMAX) : v < SMIN ? WIDTH'(SMIN) : v[WIDTH-1:0];
  endfunction
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // Pre-rotation folds the operand into the right half-plane so the micro-steps converge.
  always_comb begin
    xe = {{2{x_i[WIDTH-1]}}, x_i};
    ye = {{2{y_i[WIDTH-1]}}, y_i};
    te = {{2{theta_i[WIDTH-1]}}, theta_i};
    hi = te > DEG90;
    lo = te < -DEG90;
    flip = mode ? xe[IW-1] : (hi || lo);
    z0 = mode ? (xe[IW-1] ? (ye[IW-1] ? -DEG180 : DEG180) : '0)
              : hi ? te - DEG180 : lo ? te + DEG180 : te;
  end
  always_comb begin
    pos = md ? y[IW-1] : ~z[IW-1];
    xsh = x >>> cnt;
    ysh = y >>> cnt;
    at = IW'((ATAN[cnt[3:0]] + RND) >>> SH);
    x_nx = pos ? x - ysh : x + ysh;
    y_nx = pos ? y + xsh : y - xsh;
    z_nx = pos ? z - at : z + at;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN: if (cnt == CW'(ITER)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // The extra RUN cycle at cnt==ITER registers the saturated result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      md <= 1'b0;
      cnt <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      x_o <= '0;
      y_o <= '0;
      theta_o <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        md <= mode;
        cnt <= '0;
        x <= flip ? -xe : xe;
        y <= flip ? -ye : ye;
        z <= z0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(ITER)) begin
          x_o <= sat(x);
          y_o <= sat(y);
          theta_o <= sat(z);
        end else begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: scoreboard bench with real-arithmetic reference model
module tb_cordic_iter_engine;
  localparam int ITER = 16;
  localparam real PI = 3.14159265358979;
  typedef struct {int x; int y; int z; int tx; int ty; int tz; int acc;} exp_t;
  logic clk, rst, mode, in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [16:0] x_i, y_i, theta_i, x_o, y_o, theta_o;
  logic rdy_force, rdy_val, rdy_rand;
  int total, bad, cyc;
  real kg;
  exp_t sb[$];
  assign out_ready = rdy_force ? rdy_val : rdy_rand;
  cordic_iter_engine #(.WIDTH(17), .ANG_FRAC(8), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .y_i(y_i), .theta_i(theta_i), .out_valid(out_valid), .out_ready(out_ready),
    .x_o(x_o), .y_o(y_o), .theta_o(theta_o), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    rdy_rand = 1'b1;
    forever begin
      @(negedge clk);
      rdy_rand = 1'($urandom_range(0, 1));
    end
  end
  task automatic chk(input string nm, input int act, input int ev, input int tol, input bit ang);
    int d;
    d = act - ev;
    if (ang) begin
      while (d > 46080) d -= 92160;
      while (d < -46080) d += 92160;
    end
    total++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d tol %0d", nm, act, ev, tol);
    end
  endtask
  function automatic exp_t mk(input int x, input int y, input int z, input int tx, input int ty, input int tz);
    exp_t e;
    e.x = x; e.y = y; e.z = z; e.tx = tx; e.ty = ty; e.tz = tz; e.acc = 0;
    return e;
  endfunction
  function automatic int clamp(input real v);
    return v > 65535.0 ? 65535 : v < -65536.0 ? -65536 : int'(v);
  endfunction
  // Ideal CORDIC result: gain-scaled rotation, or gain-scaled magnitude plus atan2 angle.
  function automatic exp_t model(input logic m, input int x, input int y, input int t);
    exp_t e;
    real fx, fy, a, mag;
    if (!m) begin
      a = real'(t) * PI / (180.0 * 256.0);
      fx = kg * (real'(x) * $cos(a) - real'(y) * $sin(a));
      fy = kg * (real'(x) * $sin(a) + real'(y) * $cos(a));
      e.z = 0;
      e.tz = 2;
    end else begin
      fx = kg * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      fy = 0.0;
      e.z = int'($atan2(real'(y), real'(x)) * 180.0 * 256.0 / PI);
      e.tz = 8;
    end
    mag = $sqrt(fx * fx + fy * fy);
    e.x = clamp(fx);
    e.y = clamp(fy);
    e.tx = 24 + int'(mag * 4.0e-4);
    e.ty = e.tx;
    e.acc = 0;
    return e;
  endfunction
  task automatic issue(input logic m, input int xi, input int yi, input int ti, input exp_t e, output int n);
    mode = m;
    x_i = xi[16:0];
    y_i = yi[16:0];
    theta_i = ti[16:0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", n, 0, 0, 0);
    end else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    mode = 1'($urandom);
    x_i = 17'($urandom);
    y_i = 17'($urandom);
    theta_i = 17'($urandom);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0, 0, 0);
  endtask
  // Monitor: latency on each rising out_valid, result compare on each handshake, hold during stalls.
  initial begin
    bit prev_ov, stall;
    int hx, hy, hz;
    exp_t e;
    prev_ov = 0;
    stall = 0;
    forever begin
      @(negedge clk);
      #1;
      if (stall) begin
        chk("hold_valid", out_valid, 1, 0, 0);
        chk("hold_x", x_o, hx, 0, 0);
        chk("hold_y", y_o, hy, 0, 0);
        chk("hold_theta", theta_o, hz, 0, 0);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0, 0, 0);
        else chk("latency", cyc - sb[0].acc, ITER + 1, 0, 0);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("x_o", x_o, e.x, e.tx, 0);
        chk("y_o", y_o, e.y, e.ty, 0);
        chk("theta_o", theta_o, e.z, e.tz, 1);
      end
      stall = out_valid && !out_ready;
      hx = x_o;
      hy = y_o;
      hz = theta_o;
      prev_ov = out_valid;
    end
  end
  initial begin
    int n, m, xr, yr, tr;
    bit saw;
    total = 0;
    bad = 0;
    kg = 1.0;
    for (int i = 0; i < ITER; i++) kg = kg * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 1'b0;
    x_i = '0;
    y_i = '0;
    theta_i = '0;
    rdy_force = 1'b1;
    rdy_val = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1, 0, 0);
    chk("rst_out_valid", out_valid, 0, 0, 0);
    chk("rst_busy", busy, 0, 0, 0);
    chk("rst_x_o", x_o, 0, 0, 0);
    chk("rst_theta_o", theta_o, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 19896, 0, 11520, mk(23170, 23170, 0, 8, 8, 2), n);
    drain();
    issue(1, 16384, 16384, 0, mk(38155, 0, 11520, 8, 4, 2), n);
    drain();
    issue(0, 19896, 0, 46080, mk(-32765, 0, 0, 8, 8, 2), n);
    drain();
    issue(1, -16384, 16384, 0, mk(38155, 0, 34560, 8, 4, 2), n);
    drain();
    issue(1, 60000, 60000, 0, mk(65535, 0, 11520, 0, 8, 2), n);
    drain();
    // Backpressure in DONE, then release with a new request already waiting.
    rdy_val = 1'b0;
    issue(1, 16384, 16384, 0, mk(38155, 0, 11520, 8, 4, 2), n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_out_valid", out_valid, 1, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready, 0, 0, 0);
      chk("t4_busy", busy, 1, 0, 0);
    end
    rdy_val = 1'b1;
    issue(0, 19896, 0, 11520, mk(23170, 23170, 0, 8, 8, 2), n);
    chk("t4_accept_delay", n, 1, 0, 0);
    drain();
    // Reset in the middle of RUN discards the operation.
    issue(0, 19896, 0, 11520, mk(23170, 23170, 0, 8, 8, 2), n);
    repeat (7) @(negedge clk);
    chk("t6_run_ready", in_ready, 0, 0, 0);
    chk("t6_run_busy", busy, 1, 0, 0);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_out_valid", out_valid, 0, 0, 0);
    chk("t6_busy", busy, 0, 0, 0);
    chk("t6_in_ready", in_ready, 1, 0, 0);
    chk("t6_x_o", x_o, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    chk("t6_no_out_valid", saw, 0, 0, 0);
    issue(0, 19896, 0, 11520, mk(23170, 23170, 0, 8, 8, 2), n);
    drain();
    // Randomized operations with random output backpressure.
    rdy_force = 1'b0;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      m = int'($urandom_range(0, 1));
      xr = int'($urandom_range(0, 120000)) - 60000;
      yr = int'($urandom_range(0, 120000)) - 60000;
      tr = int'($urandom_range(0, 92160)) - 46080;
      if (m == 1 && real'(xr) * real'(xr) + real'(yr) * real'(yr) < 64.0e6) xr = 20000;
      issue(1'(m), xr, yr, tr, model(1'(m), xr, yr, tr), n);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
